fetch_stage: RTL and testbench

Instruction-fetch stage of the 3-stage processor, directly upstream of the decode/execute pipeline registers.
- Owns the program counter and issues requests to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a 2-entry skid buffer and presents {pc, instr} downstream over a valid/ready handshake.
- Accepts branch/jump redirects from execute, squashing all wrong-path fetches.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_buf.sv | 63 ++++++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the {pc, instr} entry type for the instruction-fetch stage.
package fetch_pkg;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} entries; flush beats push and pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     push_data,
    output logic [1:0] count,
    output entry_t     head
);
    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// skid-buffers responses toward decode. Handshake: an entry transfers on a cycle
// where out_valid & out_ready; out_valid never depends on out_ready.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              push, pop, issue;
    entry_t            head, push_data;

    always_comb begin
        pop             = out_valid & out_ready;
        push            = inflight_q & ~redirect;
        push_data.pc    = inflight_pc_q;
        push_data.instr = imem_rdata;
        // Slots already claimed after this cycle's pop; keeps count + inflight <= 2.
        occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = rst_n & ~redirect & (occupancy < 3'd2);

        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buf #(
        .entry_t (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = (count != 2'd0);
    // Stale storage is hidden so an empty buffer always shows zeros.
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected {pc, instr}
// is filled by the stimulus and drained by a monitor on each accepted output.
module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [15:0] out_instr;

    logic [23:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous instruction memory: mem[a] = 0x1000 + a
    always @(posedge clk) begin
        if (imem_req === 1'b1) imem_rdata <= 16'h1000 + {8'h00, imem_addr};
    end

    function automatic logic [23:0] ent(input logic [7:0] a);
        return {a, 16'h1000 + {8'h00, a}};
    endfunction

    // driver: inputs change 2 time units after the active edge
    task automatic cyc(input logic rn, input logic rd, input logic [7:0] rpc, input logic rdy);
        @(posedge clk);
        #2;
        rst_n       = rn;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got pc=%0h instr=%0h required nothing", out_pc, out_instr);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e)
                    $display("FAIL out_entry: got pc=%0h instr=%0h required pc=%0h instr=%0h",
                             out_pc, out_instr, e[23:16], e[15:0]);
                if ({out_pc, out_instr} !== e) bad++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 8'h00);
        check("rst_out_instr", out_instr, 16'h0000);

        // streaming, then back-pressure and resume
        for (int a = 0; a <= 6; a++) exp_q.push_back(ent(8'(a)));
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("a0_req", imem_req, 1'b1);
        check("a0_addr", imem_addr, 8'h00);
        check("a0_valid", out_valid, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("a1_addr", imem_addr, 8'h01);
        check("a1_valid", out_valid, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            check("stream_valid", out_valid, 1'b1);
            check("stream_addr", imem_addr, 8'(k));
        end
        for (int k = 5; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            check("bp_req", imem_req, 1'b0);
            check("bp_pc", out_pc, 8'h03);
            check("bp_instr", out_instr, 16'h1003);
        end
        for (int k = 11; k <= 14; k++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            check("resume_valid", out_valid, 1'b1);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("full_req", imem_req, 1'b0);

        // redirect with a full buffer
        exp_q.push_back(ent(8'h40));
        exp_q.push_back(ent(8'h41));
        exp_q.push_back(ent(8'h42));
        cyc(1'b1, 1'b1, 8'h40, 1'b0);
        check("redir_req", imem_req, 1'b0);
        check("redir_old_valid", out_valid, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("post_redir_valid", out_valid, 1'b0);
        check("post_redir_req", imem_req, 1'b1);
        check("post_redir_addr", imem_addr, 8'h40);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("redir_gap_valid", out_valid, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("redir_first_pc", out_pc, 8'h40);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // redirect coinciding with a pop, into the wrap-around region
        exp_q.push_back(ent(8'hFE));
        exp_q.push_back(ent(8'hFF));
        exp_q.push_back(ent(8'h00));
        exp_q.push_back(ent(8'h01));
        cyc(1'b1, 1'b1, 8'hFE, 1'b1);
        check("pop_redir_pc", out_pc, 8'h42);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("wrap_addr_fe", imem_addr, 8'hFE);
        check("wrap_gap_valid", out_valid, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("wrap_addr_ff", imem_addr, 8'hFF);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("wrap_addr_00", imem_addr, 8'h00);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("pre_rst_pc", out_pc, 8'h02);

        // one-cycle reset with a full buffer
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("mid_rst_req", imem_req, 1'b0);
        for (int a = 0; a <= 4; a++) exp_q.push_back(ent(8'(a)));
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("after_rst_valid", out_valid, 1'b0);
        check("after_rst_addr", imem_addr, 8'h00);
        check("after_rst_req", imem_req, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
